// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: 32 lines x 32 bytes.
// Hits complete with zero added latency; misses stall through WRITEBACK/ALLOCATE.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_wdata_o,
  input  logic [255:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   valid_q, dirty_q;
  logic [21:0]   tag_q  [32];
  logic [255:0]  data_q [32];

  logic [21:0]   req_tag;
  logic [4:0]    idx;
  logic [2:0]    word;
  logic [7:0]    word_lsb;
  logic [21:0]   line_tag;
  logic [255:0]  line_data;
  logic          hit;
  logic          store_hit;
  logic          fill;
  logic          unused_addr;

  assign req_tag     = cpu_addr_i[31:10];
  assign idx         = cpu_addr_i[9:5];
  assign word        = cpu_addr_i[4:2];
  assign word_lsb    = {word, 5'b0};
  assign unused_addr = ^cpu_addr_i[1:0];

  assign line_tag  = tag_q[idx];
  assign line_data = data_q[idx];
  assign hit       = cpu_req_i & valid_q[idx] & (line_tag == req_tag);

  // Every output is forced to its idle value while reset is asserted, which also
  // drops mem_req_o immediately when an in-flight transaction is aborted.
  always_comb begin
    state_d     = state_q;
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    store_hit   = 1'b0;
    fill        = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            if (hit) begin
              if (cpu_we_i) store_hit = 1'b1;
              else          cpu_rdata_o = line_data[word_lsb +: 32];
            end else begin
              cpu_stall_o = 1'b1;
              state_d     = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {line_tag, idx, 5'b0};
          mem_wdata_o = line_data;
          if (mem_ack_i) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {req_tag, idx, 5'b0};
          if (mem_ack_i) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset so they can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[idx] <= mem_rdata_i;
      tag_q[idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[idx][word_lsb +: 32] <= cpu_wdata_i;
    end
  end

endmodule
